// File: rtl/systolic_pkg.sv
// Shared sizes and pixel addressing for the 3x3 convolution kernel.
package systolic_pkg;
   localparam int unsigned IMG_DIM = 4;
   localparam int unsigned K_DIM   = 3;
   localparam int unsigned OUT_DIM = 2;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned PROD_W  = 16;
   localparam int unsigned ACC_W   = 20;
   localparam int unsigned N_PIX   = IMG_DIM * IMG_DIM;
   localparam int unsigned N_TAP   = K_DIM * K_DIM;
   localparam int unsigned N_OUT   = OUT_DIM * OUT_DIM;

   // Flat image index of the pixel under tap t for output o (o[1]=row, o[0]=col).
   function automatic logic [3:0] pix_idx(input logic [1:0] o, input logic [3:0] t);
      logic [3:0] ra;
      logic [3:0] cb;
      ra = t / 4'(K_DIM);
      cb = t % 4'(K_DIM);
      return 4'((4'(o[1]) + ra) * 4'(IMG_DIM) + 4'(o[0]) + cb);
   endfunction
endpackage

// File: rtl/systolic_conv3x3_if.sv
// Operand/result bundle between the sequencer and one processing element.
interface systolic_conv3x3_if;
   import systolic_pkg::*;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              en;
   logic              first;
   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  acc;

   modport master (output a, b, en, first, input prod, acc);
   modport slave  (input a, b, en, first, output prod, acc);
endinterface

// File: rtl/conv_pe.sv
// One MAC: registered 8x8 product plus an optional accumulator that restarts on 'first'.
module conv_pe
   import systolic_pkg::*;
#(
   parameter bit ACC_MODE = 1'b1
) (
   input logic                clk,
   input logic                rst,
   systolic_conv3x3_if.slave  pe
);
   logic [PROD_W-1:0] w_mul;
   logic [PROD_W-1:0] r_prod;
   logic [ACC_W-1:0]  r_acc;

   assign w_mul   = PROD_W'(pe.a) * PROD_W'(pe.b);
   assign pe.prod = r_prod;
   assign pe.acc  = r_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod <= '0;
         r_acc  <= '0;
      end else if (pe.en) begin
         r_prod <= w_mul;
         if (ACC_MODE)
            r_acc <= pe.first ? ACC_W'(w_mul) : r_acc + ACC_W'(w_mul);
      end
   end
endmodule

// File: rtl/systolic_conv3x3.sv
// 4x4 image * 3x3 filter valid correlation on a 1x1, 2x2 or 3x3 PE array.
module systolic_conv3x3
   import systolic_pkg::*;
#(
   parameter int unsigned PE_DIM = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i00, i01, i02, i03, i10, i11, i12, i13,
   input  logic [DATA_W-1:0] i20, i21, i22, i23, i30, i31, i32, i33,
   input  logic [DATA_W-1:0] f00, f01, f02, f10, f11, f12, f20, f21, f22,
   output logic [DATA_W-1:0] o00, o01, o10, o11,
   output logic              done
);
   localparam int unsigned NPE = PE_DIM * PE_DIM;
   localparam logic [5:0] CNT_LAST   = (PE_DIM == 1) ? 6'd35 : (PE_DIM == 2) ? 6'd8 : 6'd4;
   localparam logic [5:0] PROD_STEPS = 6'(N_OUT);
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_PUB  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (PE_DIM < 1 || PE_DIM > 3) begin : g_bad_dim
      $error("systolic_conv3x3: PE_DIM must be 1, 2 or 3");
   end

   logic [DATA_W-1:0] r_img [N_PIX];
   logic [DATA_W-1:0] r_flt [N_TAP];
   logic [DATA_W-1:0] r_res [N_OUT];
   logic [1:0]        r_state, w_state_nxt;
   logic [5:0]        r_cnt;
   logic [3:0]        r_tap;
   logic [1:0]        r_out;
   logic              r_pvld;
   logic [1:0]        r_pidx;

   logic                          w_pe_en;
   logic [NPE-1:0][PROD_W-1:0]    w_prod;
   logic [NPE-1:0][ACC_W-1:0]     w_acc;
   logic [ACC_W-1:0]              w_tree;
   logic                          w_res_we;
   logic [1:0]                    w_res_idx;
   logic [DATA_W-1:0]             w_res_val;
   logic [DATA_W-1:0]             w_pub [N_OUT];
   logic                          w_unused;

   assign w_pe_en  = (r_state == S_RUN) && ((PE_DIM != 3) || (r_cnt < PROD_STEPS));
   assign w_unused = ^{w_tree[ACC_W-1:DATA_W], w_acc, w_prod};

   // PE_DIM=3 pins each PE to a tap; PE_DIM=2 pins each PE to an output.
   for (genvar g = 0; g < NPE; g++) begin : g_pe
      localparam logic [3:0] TAP_C = 4'(g);
      localparam logic [1:0] OUT_C = 2'(g);
      logic [3:0] w_tap;
      logic [1:0] w_out;
      systolic_conv3x3_if u_bus ();

      assign w_tap       = (PE_DIM == 3) ? TAP_C : r_tap;
      assign w_out       = (PE_DIM == 2) ? OUT_C : r_out;
      assign u_bus.a     = r_flt[w_tap];
      assign u_bus.b     = r_img[pix_idx(w_out, w_tap)];
      assign u_bus.en    = w_pe_en;
      assign u_bus.first = (r_tap == 4'd0);
      assign w_prod[g]   = u_bus.prod;
      assign w_acc[g]    = u_bus.acc;

      conv_pe #(.ACC_MODE(PE_DIM != 3)) u_pe (.clk(clk), .rst(rst), .pe(u_bus.slave));
   end

   always_comb begin
      w_tree = '0;
      for (int unsigned k = 0; k < NPE; k++) w_tree = w_tree + ACC_W'(w_prod[k]);
   end

   // Where each configuration parks finished results before publishing.
   if (PE_DIM == 1) begin : g_res_serial
      assign w_res_we  = (r_state == S_RUN) && (r_tap == 4'd0) && (r_out != 2'd0);
      assign w_res_idx = r_out - 2'd1;
      assign w_res_val = w_acc[0][DATA_W-1:0];
      assign w_pub[0]  = r_res[0];
      assign w_pub[1]  = r_res[1];
      assign w_pub[2]  = r_res[2];
      assign w_pub[3]  = w_acc[0][DATA_W-1:0];
   end else if (PE_DIM == 2) begin : g_res_par
      assign w_res_we  = 1'b0;
      assign w_res_idx = '0;
      assign w_res_val = '0;
      for (genvar j = 0; j < 4; j++) begin : g_pub
         assign w_pub[j] = w_acc[j][DATA_W-1:0];
      end
   end else begin : g_res_tree
      assign w_res_we  = r_pvld;
      assign w_res_idx = r_pidx;
      assign w_res_val = w_tree[DATA_W-1:0];
      assign w_pub     = r_res;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_PUB;
         S_PUB:   w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Operands are sampled on every reset edge and frozen while running.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_img[0]  <= i00; r_img[1]  <= i01; r_img[2]  <= i02; r_img[3]  <= i03;
         r_img[4]  <= i10; r_img[5]  <= i11; r_img[6]  <= i12; r_img[7]  <= i13;
         r_img[8]  <= i20; r_img[9]  <= i21; r_img[10] <= i22; r_img[11] <= i23;
         r_img[12] <= i30; r_img[13] <= i31; r_img[14] <= i32; r_img[15] <= i33;
         r_flt[0]  <= f00; r_flt[1]  <= f01; r_flt[2]  <= f02;
         r_flt[3]  <= f10; r_flt[4]  <= f11; r_flt[5]  <= f12;
         r_flt[6]  <= f20; r_flt[7]  <= f21; r_flt[8]  <= f22;
         for (int k = 0; k < N_OUT; k++) r_res[k] <= '0;
         r_cnt  <= '0;
         r_tap  <= '0;
         r_out  <= '0;
         r_pvld <= 1'b0;
         r_pidx <= '0;
         o00    <= '0;
         o01    <= '0;
         o10    <= '0;
         o11    <= '0;
         done   <= 1'b0;
      end else begin
         r_pvld <= 1'b0;
         if (r_state == S_RUN) begin
            r_cnt  <= r_cnt + 6'd1;
            r_pvld <= w_pe_en;
            r_pidx <= r_out;
            if (PE_DIM == 3) begin
               r_out <= r_out + 2'd1;
            end else if (r_tap == 4'(N_TAP - 1)) begin
               r_tap <= '0;
               r_out <= r_out + 2'd1;
            end else begin
               r_tap <= r_tap + 4'd1;
            end
         end
         if (w_res_we) r_res[w_res_idx] <= w_res_val;
         if (r_state == S_PUB) begin
            o00  <= w_pub[0];
            o01  <= w_pub[1];
            o10  <= w_pub[2];
            o11  <= w_pub[3];
            done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_systolic_conv3x3.sv
// Directed bench: one instance per PE_DIM, each run through the same vectors and reset cases.
module tb_systolic_conv3x3;
   logic            clk = 1'b0;
   logic            rst_v [3];
   logic [7:0]      img [16];
   logic [7:0]      flt [9];
   logic [3:0][7:0] o_v [3];
   logic            done_v [3];

   int vimg [4][16];
   int vflt [4][9];
   int vexp [4][4];
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      systolic_conv3x3 #(.PE_DIM(g + 1)) u_dut (
         .clk(clk), .rst(rst_v[g]),
         .i00(img[0]),  .i01(img[1]),  .i02(img[2]),  .i03(img[3]),
         .i10(img[4]),  .i11(img[5]),  .i12(img[6]),  .i13(img[7]),
         .i20(img[8]),  .i21(img[9]),  .i22(img[10]), .i23(img[11]),
         .i30(img[12]), .i31(img[13]), .i32(img[14]), .i33(img[15]),
         .f00(flt[0]), .f01(flt[1]), .f02(flt[2]),
         .f10(flt[3]), .f11(flt[4]), .f12(flt[5]),
         .f20(flt[6]), .f21(flt[7]), .f22(flt[8]),
         .o00(o_v[g][0]), .o01(o_v[g][1]), .o10(o_v[g][2]), .o11(o_v[g][3]),
         .done(done_v[g]));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 37 : (d == 1) ? 10 : 6;
   endfunction

   task automatic load(input int v);
      for (int i = 0; i < 16; i++) img[i] = 8'(vimg[v][i]);
      for (int i = 0; i < 9; i++)  flt[i] = 8'(vflt[v][i]);
   endtask

   task automatic check_idle(input int d, input string tag);
      for (int k = 0; k < 4; k++)
         check($sformatf("pe%0d %s out%0d", d + 1, tag, k), 32'(o_v[d][k]), 32'd0);
      check($sformatf("pe%0d %s done", d + 1, tag), 32'(done_v[d]), 32'd0);
   endtask

   task automatic check_out(input int d, input int v, input string tag);
      for (int k = 0; k < 4; k++)
         check($sformatf("pe%0d %s v%0d out%0d", d + 1, tag, v, k), 32'(o_v[d][k]), 32'(vexp[v][k]));
      check($sformatf("pe%0d %s v%0d done", d + 1, tag, v), 32'(done_v[d]), 32'd1);
   endtask

   task automatic run_vec(input int d, input int v);
      load(v);
      rst_v[d] = 1'b1;
      tick();
      check_idle(d, "in-reset");
      tick();
      rst_v[d] = 1'b0;
      repeat (lat(d) - 1) tick();
      check_idle(d, "before-L");
      tick();
      check_out(d, v, "at-L");
   endtask

   task automatic mid_reset(input int d);
      load(0);
      rst_v[d] = 1'b1;
      tick();
      tick();
      rst_v[d] = 1'b0;
      repeat (lat(d) - 3) tick();
      rst_v[d] = 1'b1;
      load(1);
      tick();
      check_idle(d, "abort");
      tick();
      rst_v[d] = 1'b0;
      repeat (lat(d) - 1) tick();
      check_idle(d, "restart-before-L");
      tick();
      check_out(d, 1, "restart-at-L");
   endtask

   task automatic hold(input int d);
      logic [31:0] exp_pk;
      exp_pk = {8'(vexp[1][3]), 8'(vexp[1][2]), 8'(vexp[1][1]), 8'(vexp[1][0])};
      load(1);
      rst_v[d] = 1'b1;
      tick();
      tick();
      rst_v[d] = 1'b0;
      load(0);
      repeat (lat(d) - 1) tick();
      check_idle(d, "capture-before-L");
      tick();
      check_out(d, 1, "capture-at-L");
      for (int c = 0; c < 50; c++) begin
         tick();
         check($sformatf("pe%0d hold c%0d", d + 1, c), 32'(o_v[d]), exp_pk);
      end
      check($sformatf("pe%0d hold done", d + 1), 32'(done_v[d]), 32'd1);
   endtask

   initial begin
      vimg[0] = '{252, 165, 199, 27, 93, 28, 86, 176, 149, 110, 113, 249, 234, 207, 29, 30};
      vflt[0] = '{181, 176, 207, 111, 248, 115, 64, 95, 253};
      vexp[0] = '{89, 86, 115, 106};
      vimg[1] = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
      vflt[1] = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
      vexp[1] = '{67, 74, 34, 59};
      for (int i = 0; i < 16; i++) vimg[2][i] = 255;
      for (int i = 0; i < 9; i++)  vflt[2][i] = 255;
      vexp[2] = '{9, 9, 9, 9};
      vimg[3] = vimg[1];
      vflt[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      vexp[3] = '{4, 1, 10, 1};

      for (int d = 0; d < 3; d++) rst_v[d] = 1'b1;
      load(0);
      tick();
      tick();
      for (int d = 0; d < 3; d++) check_idle(d, "power-on");

      for (int d = 0; d < 3; d++) begin
         for (int v = 0; v < 4; v++) run_vec(d, v);
         mid_reset(d);
         hold(d);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
